control_turnos: RTL and testbench

//  Turn controller directly downstream of the initial-player selector.

---
 rtl/control_turnos.sv | 138 +++++++++++++
 tb/tb_control_turnos.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/control_turnos.sv
// rtl/control_turnos.sv - red/yellow turn controller with per-turn countdown and move counter
// Optional PAUSA_EN macro adds a `pausa` input that freezes the running turn.
module control_turnos #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TURNO_SEG = 10,
  parameter int MAX_JUG   = 42,
  localparam int W        = $clog2(TURNO_SEG + 1),
  localparam int PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         listo,
  input  logic         jugador_inicial,
  input  logic         jugada_valida,
  input  logic         fin_juego,
`ifdef PAUSA_EN
  input  logic         pausa,
`endif
  output logic         jugador_actual,
  output logic         turno_activo,
  output logic [W-1:0] tiempo_restante,
  output logic         solicitar_auto,
  output logic         timeout,
  output logic [5:0]   num_jugadas,
  output logic         tablero_lleno
);

  typedef enum logic [2:0] {
    ESPERA = 3'd0,
    TURNO  = 3'd1,
    AUTO   = 3'd2,
    CAMBIO = 3'd3,
    FIN    = 3'd4
  } estado_t;

  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [W-1:0]  SEG     = W'(TURNO_SEG);
  localparam logic [5:0]    JUG_MAX = 6'(MAX_JUG);

  estado_t       state_q, state_d;
  logic          jug_q, jug_d;
  logic [W-1:0]  tiempo_q, tiempo_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [5:0]    num_q, num_d;
  logic          timeout_q, timeout_d;
  logic          tick;
  logic          pausado;

`ifdef PAUSA_EN
  assign pausado = pausa;
`else
  assign pausado = 1'b0;
`endif

  assign tick = (pre_q == PRE_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ESPERA;
      jug_q     <= 1'b0;
      tiempo_q  <= SEG;
      pre_q     <= '0;
      num_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      jug_q     <= jug_d;
      tiempo_q  <= tiempo_d;
      pre_q     <= pre_d;
      num_q     <= num_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    jug_d     = jug_q;
    tiempo_d  = tiempo_q;
    pre_d     = pre_q;
    num_d     = num_q;
    timeout_d = 1'b0;
    case (state_q)
      ESPERA: begin
        if (listo) begin
          state_d  = TURNO;
          jug_d    = jugador_inicial;
          tiempo_d = SEG;
          pre_d    = '0;
        end
      end
      TURNO: begin
        // End of game dominates; the edge that enters FIN leaves every counter as is.
        if (fin_juego) begin
          state_d = FIN;
        end else if (!pausado) begin
          pre_d = tick ? '0 : pre_q + PW'(1);
          if (tick) tiempo_d = tiempo_q - W'(1);
          if (jugada_valida) begin
            state_d = CAMBIO;
          end else if (tick && tiempo_q == W'(1)) begin
            state_d   = AUTO;
            timeout_d = 1'b1;
          end
        end
      end
      AUTO: begin
        if (fin_juego)          state_d = FIN;
        else if (jugada_valida) state_d = CAMBIO;
      end
      CAMBIO: begin
        if (fin_juego) begin
          state_d = FIN;
        end else begin
          state_d  = TURNO;
          jug_d    = ~jug_q;
          tiempo_d = SEG;
          pre_d    = '0;
          num_d    = (num_q == JUG_MAX) ? num_q : num_q + 6'd1;
        end
      end
      FIN: begin
        state_d = FIN;
      end
      default: begin
        state_d = ESPERA;
      end
    endcase
  end

  assign jugador_actual  = jug_q;
  assign turno_activo    = (state_q == TURNO) || (state_q == AUTO);
  assign solicitar_auto  = (state_q == AUTO);
  assign tiempo_restante = tiempo_q;
  assign timeout         = timeout_q;
  assign num_jugadas     = num_q;
  assign tablero_lleno   = (num_q == JUG_MAX);

endmodule

// File: tb/tb_control_turnos.sv
// tb/tb_control_turnos.sv - self-checking bench for control_turnos (CLK_HZ=4, TURNO_SEG=3)
// Define PAUSA_EN to also exercise the pause input.
module tb_control_turnos;

  localparam int CLK_HZ = 4;
  localparam int SEG    = 3;
  localparam int MAXJ   = 42;
  localparam int TOTAL  = SEG * CLK_HZ;
  localparam int W      = $clog2(SEG + 1);

  logic         clk = 1'b0;
  logic         reset;
  logic         listo;
  logic         jugador_inicial;
  logic         jugada_valida;
  logic         fin_juego;
`ifdef PAUSA_EN
  logic         pausa;
`endif
  logic         jugador_actual;
  logic         turno_activo;
  logic [W-1:0] tiempo_restante;
  logic         solicitar_auto;
  logic         timeout;
  logic [5:0]   num_jugadas;
  logic         tablero_lleno;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_jug;
  int exp_num;
  int t_frozen;

  control_turnos #(.CLK_HZ(CLK_HZ), .TURNO_SEG(SEG), .MAX_JUG(MAXJ)) dut (
    .clk             (clk),
    .reset           (reset),
    .listo           (listo),
    .jugador_inicial (jugador_inicial),
    .jugada_valida   (jugada_valida),
    .fin_juego       (fin_juego),
`ifdef PAUSA_EN
    .pausa           (pausa),
`endif
    .jugador_actual  (jugador_actual),
    .turno_activo    (turno_activo),
    .tiempo_restante (tiempo_restante),
    .solicitar_auto  (solicitar_auto),
    .timeout         (timeout),
    .num_jugadas     (num_jugadas),
    .tablero_lleno   (tablero_lleno)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_jug"},     32'(jugador_actual),  0);
    chk({tag, "_tiempo"},  32'(tiempo_restante), SEG);
    chk({tag, "_num"},     32'(num_jugadas),     0);
    chk({tag, "_activo"},  32'(turno_activo),    0);
    chk({tag, "_auto"},    32'(solicitar_auto),  0);
    chk({tag, "_timeout"}, 32'(timeout),         0);
    chk({tag, "_lleno"},   32'(tablero_lleno),   0);
  endtask

  // Starts on the first cycle of a turn; the move arrives d cycles into it.
  // Seconds left after k cycles is SEG - k/CLK_HZ until the budget of TOTAL cycles is spent.
  task automatic play_turn(input int d, input bit hold2);
    for (int k = 0; k <= d; k++) begin
      chk("turn_tiempo",  32'(tiempo_restante), (k < TOTAL) ? SEG - k / CLK_HZ : 0);
      chk("turn_activo",  32'(turno_activo),    1);
      chk("turn_auto",    32'(solicitar_auto),  (k >= TOTAL) ? 1 : 0);
      chk("turn_timeout", 32'(timeout),         (k == TOTAL) ? 1 : 0);
      chk("turn_jug",     32'(jugador_actual),  exp_jug);
      chk("turn_num",     32'(num_jugadas),     exp_num);
      if (k == d) jugada_valida = 1'b1;
      step();
    end
    if (!hold2) jugada_valida = 1'b0;
    chk("cambio_activo",  32'(turno_activo),   0);
    chk("cambio_auto",    32'(solicitar_auto), 0);
    chk("cambio_timeout", 32'(timeout),        0);
    chk("cambio_jug",     32'(jugador_actual), exp_jug);
    step();
    jugada_valida = 1'b0;
    exp_jug = 1 - exp_jug;
    exp_num = (exp_num < MAXJ) ? exp_num + 1 : MAXJ;
    chk("next_jug",    32'(jugador_actual),  exp_jug);
    chk("next_tiempo", 32'(tiempo_restante), SEG);
    chk("next_num",    32'(num_jugadas),     exp_num);
    chk("next_lleno",  32'(tablero_lleno),   (exp_num == MAXJ) ? 1 : 0);
    chk("next_activo", 32'(turno_activo),    1);
  endtask

  initial begin
    reset = 1'b0; listo = 1'b0; jugador_inicial = 1'b0;
    jugada_valida = 1'b0; fin_juego = 1'b0;
`ifdef PAUSA_EN
    pausa = 1'b0;
`endif
    step(); step();
    chk_reset("rst");
    reset = 1'b1;
    fin_juego = 1'b1;
    step(); step();
    fin_juego = 1'b0;
    chk("espera_hold", 32'(turno_activo), 0);

    // T1: start with yellow; the latched player must not follow the input afterwards
    jugador_inicial = 1'b1; listo = 1'b1;
    step();
    jugador_inicial = 1'b0;
    exp_jug = 1; exp_num = 0;
    chk("t1_jug",    32'(jugador_actual),  1);
    chk("t1_tiempo", 32'(tiempo_restante), SEG);
    chk("t1_activo", 32'(turno_activo),    1);

    play_turn(2, 1'b0);           // T2
    play_turn(TOTAL + 2, 1'b0);   // T3: timeout then automatic move
    play_turn(TOTAL - 1, 1'b1);   // T4: move on the expiring tick, extra pulse into CAMBIO
    play_turn(TOTAL, 1'b0);       // move during the timeout cycle itself

`ifdef PAUSA_EN
    // T6: pause one cycle into the turn, try a move while paused, then resume
    step();
    pausa = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 7) jugada_valida = 1'b1;
      step();
      jugada_valida = 1'b0;
      chk("pausa_tiempo", 32'(tiempo_restante), SEG);
      chk("pausa_activo", 32'(turno_activo),    1);
      chk("pausa_jug",    32'(jugador_actual),  exp_jug);
    end
    pausa = 1'b0;
    for (int k = 0; k < CLK_HZ; k++) step();
    chk("pausa_resume", 32'(tiempo_restante), SEG - 1);
    jugada_valida = 1'b1;
    step();
    jugada_valida = 1'b0;
    step();
    exp_jug = 1 - exp_jug;
    exp_num = exp_num + 1;
    chk("pausa_jug_after", 32'(jugador_actual), exp_jug);
    chk("pausa_num_after", 32'(num_jugadas),    exp_num);
`endif

    // T5: fill the board with randomly timed moves, then one more past the ceiling
    while (exp_num < MAXJ) play_turn($urandom_range(0, TOTAL + 3), 1'($urandom_range(0, 1)));
    play_turn(1, 1'b0);

    // fin_juego mid-turn, away from a tick: everything freezes, moves are ignored
    for (int k = 0; k < 5; k++) step();
    t_frozen = SEG - 5 / CLK_HZ;
    fin_juego = 1'b1;
    step();
    for (int k = 0; k < 10; k++) begin
      jugada_valida = (k == 3);
      if (k == 6) fin_juego = 1'b0;
      chk("fin_activo", 32'(turno_activo),    0);
      chk("fin_auto",   32'(solicitar_auto),  0);
      chk("fin_tiempo", 32'(tiempo_restante), t_frozen);
      chk("fin_jug",    32'(jugador_actual),  exp_jug);
      chk("fin_num",    32'(num_jugadas),     MAXJ);
      chk("fin_lleno",  32'(tablero_lleno),   1);
      step();
    end
    jugada_valida = 1'b0;
    reset = 1'b0; listo = 1'b0;
    step();
    chk_reset("rst2");

    // second game: random first player, then fin_juego arrives during CAMBIO
    reset = 1'b1; listo = 1'b1;
    jugador_inicial = 1'($urandom_range(0, 1));
    exp_jug = int'(jugador_inicial); exp_num = 0;
    step();
    play_turn(3, 1'b0);
    step();
    jugada_valida = 1'b1;
    step();
    jugada_valida = 1'b0;
    fin_juego = 1'b1;
    step();
    chk("fin_cambio_jug",    32'(jugador_actual), exp_jug);
    chk("fin_cambio_num",    32'(num_jugadas),    exp_num);
    chk("fin_cambio_activo", 32'(turno_activo),   0);

    // asynchronous reset between clock edges, then listo is sampled again
    #3 reset = 1'b0;
    #1 chk_reset("rst_async");
    fin_juego = 1'b0;
    step();
    reset = 1'b1;
    jugador_inicial = ~jugador_inicial;
    step();
    chk("restart_activo", 32'(turno_activo),   1);
    chk("restart_jug",    32'(jugador_actual), 32'(jugador_inicial));
    chk("restart_num",    32'(num_jugadas),    0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
